// File: rtl/led_fade_driver_if.sv
// Pattern handshake between a pattern producer and led_fade_driver.
// Valid/ready: a pattern moves on a rising hwclk when pattern_valid and
// pattern_ready are both high. A producer that sees ready low keeps valid and
// data stable until the transfer happens. Ready never depends on valid.
interface led_fade_driver_if #(
   parameter int N_LEDS = 8
);
   logic [N_LEDS-1:0] pattern_in;
   logic              pattern_valid;
   logic              pattern_ready;

   modport master (
      output pattern_in,
      output pattern_valid,
      input  pattern_ready
   );

   modport slave (
      input  pattern_in,
      input  pattern_valid,
      output pattern_ready
   );
endinterface

// File: rtl/led_fade_driver.sv
// LED output stage with PWM cross-fade between patterns.
// A new pattern fades the current one down to dark, swaps it in, then fades it
// up to full brightness. Brightness moves one STEP per 256-tick PWM frame.
module led_fade_driver #(
   parameter int N_LEDS   = 8,
   parameter int PRESCALE = 16,
   parameter int STEP     = 8
) (
   input  logic              hwclk,
   input  logic              rst_n,
   led_fade_driver_if.slave  pat_if,
   output logic              busy,
   output logic [N_LEDS-1:0] led,
   output logic [1:0]        o_dbg_state,
   output logic [8:0]        o_dbg_level
);

   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [8:0]    STEP9   = 9'(STEP);
   localparam logic [9:0]    STEP10  = 10'(STEP);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_HOLD     = 2'd1,
      S_FADE_OUT = 2'd2,
      S_FADE_IN  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PW-1:0]     r_pre;
   logic [7:0]        r_pwm;
   logic [8:0]        r_level;
   logic [8:0]        w_level_nxt;
   logic [N_LEDS-1:0] r_cur_pat;
   logic [N_LEDS-1:0] w_cur_pat_nxt;
   logic [N_LEDS-1:0] r_next_pat;
   logic [N_LEDS-1:0] w_next_pat_nxt;
   logic [N_LEDS-1:0] r_led;
   logic              w_tick;
   logic              w_frame_end;
   logic              w_xfer;
   logic              w_lit;
   logic [9:0]        w_up_sum;
   logic [8:0]        w_level_up;
   logic [8:0]        w_level_dn;

   assign w_tick      = (r_pre == PRE_MAX);
   assign w_frame_end = w_tick && (r_pwm == 8'hFF);

   // Ready is a function of state only, so it can never loop back through valid.
   assign pat_if.pattern_ready = (r_state == S_IDLE) || (r_state == S_HOLD);
   assign w_xfer               = pat_if.pattern_valid && pat_if.pattern_ready;
   assign busy                 = (r_state == S_FADE_OUT) || (r_state == S_FADE_IN);

   // Saturating level steps: clamp at 0 and 256 for STEP values that do not divide 256.
   assign w_up_sum   = {1'b0, r_level} + STEP10;
   assign w_level_up = (w_up_sum >= 10'd256) ? 9'd256 : w_up_sum[8:0];
   assign w_level_dn = (r_level > STEP9) ? (r_level - STEP9) : 9'd0;

   // Pixel is lit for the first 'level' counts of every 256-count frame.
   assign w_lit = ({1'b0, r_pwm} < r_level);

   // Prescaler: free-running 0..PRESCALE-1, tick on the last count.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   // PWM counter: advances once per tick and wraps 255 -> 0.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= 8'd0;
      end else if (w_tick) begin
         r_pwm <= r_pwm + 8'd1;
      end
   end

   // FSM state and fade datapath registers.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_level    <= 9'd0;
         r_cur_pat  <= '0;
         r_next_pat <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_level    <= w_level_nxt;
         r_cur_pat  <= w_cur_pat_nxt;
         r_next_pat <= w_next_pat_nxt;
      end
   end

   // Next-state logic: accept patterns when idle/holding, step level on frame ends.
   always_comb begin
      w_state_nxt    = r_state;
      w_level_nxt    = r_level;
      w_cur_pat_nxt  = r_cur_pat;
      w_next_pat_nxt = r_next_pat;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_cur_pat_nxt = pat_if.pattern_in;
               w_state_nxt   = S_FADE_IN;
            end
         end
         S_HOLD: begin
            // Level stays at full brightness here even if a frame ends.
            if (w_xfer) begin
               w_next_pat_nxt = pat_if.pattern_in;
               w_state_nxt    = S_FADE_OUT;
            end
         end
         S_FADE_OUT: begin
            if (w_frame_end) begin
               w_level_nxt = w_level_dn;
               if (w_level_dn == 9'd0) begin
                  w_cur_pat_nxt = r_next_pat;
                  w_state_nxt   = S_FADE_IN;
               end
            end
         end
         S_FADE_IN: begin
            if (w_frame_end) begin
               w_level_nxt = w_level_up;
               if (w_level_up == 9'd256) begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered LED drive, one cycle behind the PWM counter.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_led <= '0;
      end else begin
         r_led <= r_cur_pat & {N_LEDS{w_lit}};
      end
   end

   assign led         = r_led;
   assign o_dbg_state = r_state;
   assign o_dbg_level = r_level;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver. Instance A (PRESCALE=1, STEP=8) covers
// reset, first fade-in, cross-fade, backpressure and mid-fade reset. Instance B
// (PRESCALE=2, STEP=7) covers prescaling and saturating level steps.
module tb_led_fade_driver;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_HOLD     = 2'd1;
   localparam logic [1:0] S_FADE_OUT = 2'd2;
   localparam logic [1:0] S_FADE_IN  = 2'd3;

   logic       hwclk;
   logic       rst_a_n;
   logic       rst_b_n;
   logic       busy_a;
   logic       busy_b;
   logic [7:0] led_a;
   logic [7:0] led_b;
   logic [1:0] st_a;
   logic [1:0] st_b;
   logic [8:0] lv_a;
   logic [8:0] lv_b;

   int         n_checks;
   int         n_errs;
   int         e;
   int         cnt;
   logic [7:0] led_or;
   logic [7:0] exp_q[$];

   led_fade_driver_if #(.N_LEDS(8)) if_a ();
   led_fade_driver_if #(.N_LEDS(8)) if_b ();

   led_fade_driver #(.N_LEDS(8), .PRESCALE(1), .STEP(8)) dut_a (
      .hwclk       (hwclk),
      .rst_n       (rst_a_n),
      .pat_if      (if_a),
      .busy        (busy_a),
      .led         (led_a),
      .o_dbg_state (st_a),
      .o_dbg_level (lv_a)
   );

   led_fade_driver #(.N_LEDS(8), .PRESCALE(2), .STEP(7)) dut_b (
      .hwclk       (hwclk),
      .rst_n       (rst_b_n),
      .pat_if      (if_b),
      .busy        (busy_b),
      .led         (led_b),
      .o_dbg_state (st_b),
      .o_dbg_level (lv_b)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   initial begin
      hwclk = 1'b0;
      forever #5 hwclk = ~hwclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
      end
   endtask

   // Advance n rising edges; sample on the following falling edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge hwclk);
         e++;
         led_or |= led_a;
      end
   endtask

   task automatic cyc_to(input int target);
      cyc(target - e);
   endtask

   // Count samples over n edges where the selected LED bus equals val.
   task automatic measure(input bit sel_b, input int n, input logic [7:0] val, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if ((sel_b ? led_b : led_a) == val) c++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      e        = 0;
      led_or   = 8'h00;
      rst_a_n  = 1'b0;
      rst_b_n  = 1'b0;
      if_a.pattern_valid = 1'b1;
      if_a.pattern_in    = 8'hA5;
      if_b.pattern_valid = 1'b0;
      if_b.pattern_in    = 8'h00;

      // ---------------- instance A: reset with valid held high
      cyc(5);
      check("rst_led",   {24'd0, led_a}, 32'h00);
      check("rst_ready", {31'd0, if_a.pattern_ready}, 32'd1);
      check("rst_busy",  {31'd0, busy_a}, 32'd0);
      check("rst_state", {30'd0, st_a}, {30'd0, S_IDLE});
      check("rst_level", {23'd0, lv_a}, 32'd0);

      rst_a_n = 1'b1;
      e       = 0;
      led_or  = 8'h00;
      exp_q.push_back(8'hA5);
      #1;
      check("no_xfer_before_edge", {30'd0, st_a}, {30'd0, S_IDLE});

      // first edge after release takes the pattern
      cyc(1);
      check("first_busy",  {31'd0, busy_a}, 32'd1);
      check("first_ready", {31'd0, if_a.pattern_ready}, 32'd0);
      check("first_state", {30'd0, st_a}, {30'd0, S_FADE_IN});
      if_a.pattern_valid = 1'b0;
      if_a.pattern_in    = 8'h00;

      cyc_to(255);
      check("fi_lvl_pre_frame", {23'd0, lv_a}, 32'd0);
      cyc_to(256);
      check("fi_lvl_8", {23'd0, lv_a}, 32'd8);
      measure(1'b0, 256, 8'hA5, cnt);
      check("fi_duty_8", cnt, 32'd8);
      check("fi_lvl_16", {23'd0, lv_a}, 32'd16);
      measure(1'b0, 256, 8'hA5, cnt);
      check("fi_duty_16", cnt, 32'd16);
      check("fi_lvl_24", {23'd0, lv_a}, 32'd24);

      cyc_to(8191);
      check("fi_lvl_248",   {23'd0, lv_a}, 32'd248);
      check("fi_state_248", {30'd0, st_a}, {30'd0, S_FADE_IN});
      cyc_to(8192);
      check("hold_state", {30'd0, st_a}, {30'd0, S_HOLD});
      check("hold_level", {23'd0, lv_a}, 32'd256);
      check("hold_busy",  {31'd0, busy_a}, 32'd0);
      check("hold_ready", {31'd0, if_a.pattern_ready}, 32'd1);
      check("fi_unlit_bits", {24'd0, led_or & 8'h5A}, 32'h00);
      cyc(1);
      check("hold_led_a5", {24'd0, led_a}, {24'd0, exp_q.pop_front()});
      measure(1'b0, 256, 8'hA5, cnt);
      check("hold_duty_full", cnt, 32'd256);

      // ---------------- cross-fade, transfer lands on a frame_end edge
      cyc_to(8703);
      if_a.pattern_valid = 1'b1;
      if_a.pattern_in    = 8'h0F;
      exp_q.push_back(8'h0F);
      cyc(1);
      check("fo_state",     {30'd0, st_a}, {30'd0, S_FADE_OUT});
      check("fo_level_256", {23'd0, lv_a}, 32'd256);
      check("fo_busy",      {31'd0, busy_a}, 32'd1);
      check("fo_ready",     {31'd0, if_a.pattern_ready}, 32'd0);
      if_a.pattern_valid = 1'b0;
      if_a.pattern_in    = 8'h00;

      cyc_to(8960);
      check("fo_lvl_248", {23'd0, lv_a}, 32'd248);
      measure(1'b0, 256, 8'hA5, cnt);
      check("fo_duty_248", cnt, 32'd248);

      cyc_to(16895);
      check("fo_lvl_8",   {23'd0, lv_a}, 32'd8);
      check("fo_state_8", {30'd0, st_a}, {30'd0, S_FADE_OUT});
      cyc_to(16896);
      check("swap_level", {23'd0, lv_a}, 32'd0);
      check("swap_state", {30'd0, st_a}, {30'd0, S_FADE_IN});
      measure(1'b0, 256, 8'h00, cnt);
      check("swap_dark_frame", cnt, 32'd256);
      led_or = 8'h00;
      measure(1'b0, 256, 8'h0F, cnt);
      check("fi2_duty_8", cnt, 32'd8);
      check("fi2_old_bits", {24'd0, led_or & 8'hF0}, 32'h00);

      // ---------------- backpressure during fade-in
      cyc_to(20000);
      if_a.pattern_valid = 1'b1;
      if_a.pattern_in    = 8'hFF;
      cyc(1);
      check("bp_ready", {31'd0, if_a.pattern_ready}, 32'd0);
      check("bp_state", {30'd0, st_a}, {30'd0, S_FADE_IN});
      cyc_to(25087);
      check("bp_state_late", {30'd0, st_a}, {30'd0, S_FADE_IN});
      check("bp_lvl_late",   {23'd0, lv_a}, 32'd248);
      cyc(1);
      check("bp_hold_state", {30'd0, st_a}, {30'd0, S_HOLD});
      check("bp_hold_ready", {31'd0, if_a.pattern_ready}, 32'd1);
      check("bp_hold_busy",  {31'd0, busy_a}, 32'd0);
      cyc(1);
      check("bp_taken_state", {30'd0, st_a}, {30'd0, S_FADE_OUT});
      check("bp_taken_busy",  {31'd0, busy_a}, 32'd1);
      check("hold_led_0f",    {24'd0, led_a}, {24'd0, exp_q.pop_front()});
      if_a.pattern_valid = 1'b0;
      if_a.pattern_in    = 8'h00;

      // ---------------- asynchronous reset in the middle of a fade-out
      cyc_to(29300);
      check("mid_lvl_128",   {23'd0, lv_a}, 32'd128);
      check("mid_state_fo",  {30'd0, st_a}, {30'd0, S_FADE_OUT});
      rst_a_n = 1'b0;
      #1;
      check("arst_state", {30'd0, st_a}, {30'd0, S_IDLE});
      check("arst_level", {23'd0, lv_a}, 32'd0);
      check("arst_led",   {24'd0, led_a}, 32'h00);
      check("arst_busy",  {31'd0, busy_a}, 32'd0);
      check("arst_ready", {31'd0, if_a.pattern_ready}, 32'd1);

      // ---------------- instance B: PRESCALE=2, STEP=7 saturation
      check("b_rst_state", {30'd0, st_b}, {30'd0, S_IDLE});
      check("b_rst_led",   {24'd0, led_b}, 32'h00);
      check("b_rst_ready", {31'd0, if_b.pattern_ready}, 32'd1);
      if_b.pattern_valid = 1'b1;
      if_b.pattern_in    = 8'h3C;
      rst_b_n = 1'b1;
      e       = 0;
      cyc(1);
      check("b_first_state", {30'd0, st_b}, {30'd0, S_FADE_IN});
      check("b_first_busy",  {31'd0, busy_b}, 32'd1);
      if_b.pattern_valid = 1'b0;
      if_b.pattern_in    = 8'h00;

      cyc_to(511);
      check("b_lvl_pre_frame", {23'd0, lv_b}, 32'd0);
      cyc_to(512);
      check("b_lvl_7", {23'd0, lv_b}, 32'd7);
      measure(1'b1, 512, 8'h3C, cnt);
      check("b_duty_7", cnt, 32'd14);
      check("b_lvl_14", {23'd0, lv_b}, 32'd14);

      cyc_to(18943);
      check("b_lvl_252",   {23'd0, lv_b}, 32'd252);
      check("b_state_252", {30'd0, st_b}, {30'd0, S_FADE_IN});
      cyc(1);
      check("b_lvl_clamp",  {23'd0, lv_b}, 32'd256);
      check("b_hold_state", {30'd0, st_b}, {30'd0, S_HOLD});
      cyc_to(19456);
      check("b_lvl_stays",   {23'd0, lv_b}, 32'd256);
      check("b_state_stays", {30'd0, st_b}, {30'd0, S_HOLD});
      cyc(1);
      check("b_hold_led", {24'd0, led_b}, 32'h3C);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
